// File: rtl/mult_8x8_seq_ctrl.sv
// Purpose: 8x8 multiply built from four passes through one external 4x4 sub-multiplier.
// Latency: 5 cycles from accept to out_valid, or 1 cycle when an operand is zero and bypass is on.
// Backpressure: one job at a time; in_ready only in IDLE; R/out_valid hold in DONE until out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; A, B sampled on accept
//   out_valid/out_ready   result handshake; R is the 16-bit product (mod 2^16)
//   sub_A/sub_B/sub_sel   nibble operands and variant select to the sub-multiplier
//   sub_R                 combinational 8-bit product from the sub-multiplier
//   busy                  high whenever a job is in flight or waiting to be taken
module mult_8x8_seq_ctrl #(
    parameter bit HH_SEL      = 1'b1,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] R,
    output logic [3:0]  sub_A,
    output logic [3:0]  sub_B,
    output logic        sub_sel,
    input  logic [7:0]  sub_R,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] r_q, r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            r_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        r_d     = r_q;
        sub_A   = 4'h0;
        sub_B   = 4'h0;
        sub_sel = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = A;
                    b_d   = B;
                    acc_d = 16'h0000;
                    // A zero operand makes the product zero regardless of
                    // the sub-multiplier variant, so skip the four passes.
                    if (ZERO_BYPASS && ((A == 8'h00) || (B == 8'h00))) begin
                        r_d     = 16'h0000;
                        state_d = DONE;
                    end else begin
                        state_d = P0;
                    end
                end
            end
            P0: begin
                sub_A   = a_q[3:0];
                sub_B   = b_q[3:0];
                acc_d   = acc_q + {8'h00, sub_R};
                state_d = P1;
            end
            P1: begin
                sub_A   = a_q[3:0];
                sub_B   = b_q[7:4];
                acc_d   = acc_q + {4'h0, sub_R, 4'h0};
                state_d = P2;
            end
            P2: begin
                sub_A   = a_q[7:4];
                sub_B   = b_q[3:0];
                acc_d   = acc_q + {4'h0, sub_R, 4'h0};
                state_d = P3;
            end
            P3: begin
                sub_A   = a_q[7:4];
                sub_B   = b_q[7:4];
                sub_sel = HH_SEL;
                // Top partial: bits shifted past bit 15 are dropped, giving
                // the mod 2^16 wrap for approximate sub-products.
                acc_d   = acc_q + {sub_R, 8'h00};
                r_d     = acc_d;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode straight from the state register so that an
    // asynchronous reset forces them to their idle values immediately.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign R         = r_q;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
module tb_mult_8x8_seq_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, sub_sel, busy;
    logic [7:0]  A, B, sub_R;
    logic [15:0] R;
    logic [3:0]  sub_A, sub_B;
    logic        force_255;

    // Sub-multiplier model: exact 4x4 product, or stuck at 255 for the wrap test.
    assign sub_R = force_255 ? 8'hFF : ({4'h0, sub_A} * {4'h0, sub_B});

    mult_8x8_seq_ctrl #(.HH_SEL(1'b1), .ZERO_BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .R(R),
        .sub_A(sub_A), .sub_B(sub_B), .sub_sel(sub_sel), .sub_R(sub_R),
        .busy(busy)
    );

    // Second instance with the zero shortcut disabled; shares A/B with the first.
    logic        nb_in_valid, nb_in_ready, nb_out_valid, nb_sub_sel, nb_busy;
    logic        nb_out_ready;
    logic [15:0] nb_R;
    logic [3:0]  nb_sub_A, nb_sub_B;
    logic [7:0]  nb_sub_R;
    assign nb_out_ready = 1'b1;
    assign nb_sub_R = {4'h0, nb_sub_A} * {4'h0, nb_sub_B};

    mult_8x8_seq_ctrl #(.HH_SEL(1'b1), .ZERO_BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nb_in_valid), .in_ready(nb_in_ready), .A(A), .B(B),
        .out_valid(nb_out_valid), .out_ready(nb_out_ready), .R(nb_R),
        .sub_A(nb_sub_A), .sub_B(nb_sub_B), .sub_sel(nb_sub_sel), .sub_R(nb_sub_R),
        .busy(nb_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    logic [3:0] seq_a[4];
    logic [3:0] seq_b[4];
    logic       seq_s[4];
    int         sub_active;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        int          lat;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: a product leaves the DUT when out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got R=%0d expected no output", R);
            end else begin
                check("sb_R", R, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_r,
                           input int exp_lat, input string tag);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        A = a;
        B = b;
        in_valid = 1'b1;
        sb.push_back(exp_r);
        sub_active = 0;
        lat = 0;
        do begin
            step();
            in_valid = 1'b0;
            lat++;
            if (!out_valid && lat <= 4) begin
                seq_a[lat-1] = sub_A;
                seq_b[lat-1] = sub_B;
                seq_s[lat-1] = sub_sel;
            end
            if (sub_A != 4'h0 || sub_B != 4'h0) sub_active++;
        end while (!out_valid && lat < 30);
        check({tag, "_latency"}, lat, exp_lat);
        if (out_ready) step();
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;

        vecs[0] = '{8'd200, 8'd100, 16'd20000, 5};
        vecs[1] = '{8'd255, 8'd255, 16'd65025, 5};
        vecs[2] = '{8'd1,   8'd1,   16'd1,     5};
        vecs[3] = '{8'd0,   8'd77,  16'd0,     1};
        vecs[4] = '{8'd77,  8'd0,   16'd0,     1};
        vecs[5] = '{8'd16,  8'd17,  16'd272,   5};

        rst_n = 1'b0; in_valid = 1'b0; nb_in_valid = 1'b0;
        A = 8'h00; B = 8'h00; out_ready = 1'b1; force_255 = 1'b0;
        #1;
        check("rst_R", R, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sub", {sub_A, sub_B, sub_sel}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, $sformatf("vec%0d", i));
            if (i == 0) begin
                check("seq_p0", {seq_a[0], seq_b[0], seq_s[0]}, {4'd8,  4'd4, 1'b0});
                check("seq_p1", {seq_a[1], seq_b[1], seq_s[1]}, {4'd8,  4'd6, 1'b0});
                check("seq_p2", {seq_a[2], seq_b[2], seq_s[2]}, {4'd12, 4'd4, 1'b0});
                check("seq_p3", {seq_a[3], seq_b[3], seq_s[3]}, {4'd12, 4'd6, 1'b1});
            end
            if (vecs[i].lat == 1) check($sformatf("vec%0d_bypass_sub_idle", i), sub_active, 0);
        end

        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_job(ra, rb, 16'(ra * rb), (ra == 0 || rb == 0) ? 1 : 5, "rand");
        end

        force_255 = 1'b1;
        run_job(8'h11, 8'h11, 16'd8159, 5, "wrap");
        force_255 = 1'b0;

        // Zero operand with the shortcut disabled still takes the full path.
        A = 8'd0; B = 8'd77; nb_in_valid = 1'b1;
        lat = 0;
        do begin
            step();
            nb_in_valid = 1'b0;
            lat++;
        end while (!nb_out_valid && lat < 30);
        check("nobypass_latency", lat, 5);
        check("nobypass_R", nb_R, 0);
        step();
        check("nobypass_idle", {nb_busy, nb_in_ready}, 2'b01);

        // Back-pressure: hold the result for 10 cycles while in_valid is asserted.
        out_ready = 1'b0;
        run_job(8'd40, 8'd3, 16'd120, 5, "bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; A = 8'd9; B = 8'd9;
            step();
            check("bp_hold", {out_valid, in_ready, busy, R}, {1'b1, 1'b0, 1'b1, 16'd120});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release", {out_valid, in_ready}, 2'b01);

        // Asynchronous reset in P2 aborts the job.
        A = 8'd50; B = 8'd60; in_valid = 1'b1;
        sb.push_back(16'd3000);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("p2_operands", {sub_A, sub_B}, {4'd3, 4'd12});
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {out_valid, busy, sub_A, sub_B, sub_sel}, 0);
        check("midrst_R", R, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        run_job(8'd3, 8'd5, 16'd15, 5, "post_rst");

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
Name: mult_8x8_seq_ctrl

Overview:
- Sequencing controller that computes one 8x8 product over four cycles by reusing a single external 4x4 sub-multiplier instance instead of instantiating four.
- Drives the sub-multiplier operands, selects its variant per partial (non-corrected vs high-half variant), and shift-accumulates the 8-bit partials into a 16-bit result.
- Sits between a valid/ready producer of operand pairs and a valid/ready consumer of products in area-constrained FPGA builds of the approximate multiplier family.

Parameters:
- HH_SEL, 1, value driven on sub_sel during the high×high partial; 0 uses the non-corrected variant for all four partials.
- ZERO_BYPASS, 1, 1 enables the zero-operand shortcut; 0 always runs all four partials.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept an operand pair.
- A  input  8  multiplicand; sampled on accept.
- B  input  8  multiplier; sampled on accept.
- out_valid  output  1  R holds a completed product.
- out_ready  input  1  consumer accepts R.
- R  output  16  product, modulo 2^16.
- sub_A  output  4  operand nibble to the sub-multiplier.
- sub_B  output  4  operand nibble to the sub-multiplier.
- sub_sel  output  1  sub-multiplier variant select; 1 = high-half variant.
- sub_R  input  8  combinational product returned by the sub-multiplier in the same cycle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; A/B registers=0; acc=0; R=0; out_valid=0; sub_A=0; sub_B=0; sub_sel=0; in_ready=1 after release; busy=0.
- States: IDLE, P0, P1, P2, P3, DONE.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready: latch A and B, clear acc.
- Zero bypass: if ZERO_BYPASS=1 and (A==0 or B==0), accept goes directly to DONE with acc=0. Otherwise accept goes to P0.
- Each Pn state lasts exactly one cycle. sub_A/sub_B/sub_sel are registered-state decoded, and acc updates at the end of the state:
  - P0: sub_A=Al, sub_B=Bl, sub_sel=0; acc += sub_R.
  - P1: sub_A=Al, sub_B=Bh, sub_sel=0; acc += sub_R<<4.
  - P2: sub_A=Ah, sub_B=Bl, sub_sel=0; acc += sub_R<<4.
  - P3: sub_A=Ah, sub_B=Bh, sub_sel=HH_SEL; acc += sub_R<<8; then go to DONE.
- Outside P0–P3, sub_A=sub_B=0 and sub_sel=0.
- Arithmetic: acc is 16 bits and all additions wrap modulo 2^16. No saturation; overflow is only possible with an approximate sub_R.
- R = acc, visible while out_valid=1. R holds its last value in other states and is not cleared on accept.
- DONE: out_valid=1. On out_ready=1, go to IDLE and drop out_valid next cycle. R and out_valid stay stable while out_ready=0 (no bubbles, no changes).
- Latency from accept edge to out_valid rising: normal 5 cycles; bypass 1 cycle.
- Throughput: one product per 6 cycles with out_ready tied high. No overlap of jobs; back-to-back accept is possible the cycle after DONE exits.
- in_valid during a busy state is ignored; A/B are not re-sampled.
- Async reset mid-operation aborts the job with no output, and all outputs take their reset values immediately.

Test Plan:
- Exact sub-multiplier model (sub_R = sub_A*sub_B), A=200, B=100, out_ready=1 → sub operand sequence (8,4),(8,6),(12,4),(12,6); sub_sel high only in P3; out_valid 5 cycles after accept; R=20000.
- A=255, B=255 → R=65025; A=1, B=1 → R=1; then 500 random pairs compared against A*B.
- Wrap check: sub_R forced to 255 every cycle, A=B=0x11 → R = (255*289) mod 65536 = 8159.
- Bypass: A=0, B=77 → out_valid one cycle after accept, R=0, no sub_A/sub_B activity. With ZERO_BYPASS=0 → 5-cycle latency, R=0.
- Back-pressure: out_ready held low for 10 cycles in DONE → R and out_valid stable, in_ready=0 and in_valid ignored. Release → out_valid falls next cycle, in_ready=1.
- rst_n pulsed low during P2 → all outputs take reset values immediately. After release, a fresh A=3, B=5 yields R=15 with normal latency.
